wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-stage register file for the pipelined datapath. It consumes the third-stage pipeline outputs (latched ALU result, write enable and write select) and commits the result into a 32-entry architectural register array on the clock edge. It provides two combinational read ports to the decode/S1 stage, with same-cycle write-to-read bypass. It also provides a non-bypassed debug read port and a committed-write counter for verification.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, select width; array depth is 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes; when 0 register 0 is an ordinary register

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- wb_we  input  1  write enable from S3 stage (S3_WriteEnable)
- wb_sel  input  ADDR_W  destination register from S3 stage (S3_WriteSelect)
- wb_data  input  DATA_W  write data from S3 stage (ALUOut)
- rd_sel1  input  ADDR_W  read port 1 select
- rd_data1  output  DATA_W  read port 1 data, combinational
- rd_sel2  input  ADDR_W  read port 2 select
- rd_data2  output  DATA_W  read port 2 data, combinational
- dbg_sel  input  ADDR_W  debug read select
- dbg_data  output  DATA_W  debug read data, combinational, array contents only
- wr_count  output  32  number of committed writes since reset, saturating

## Operation
- Commit condition: `commit = wb_we & ~rst & ~(ZERO_REG & (wb_sel == 0))`.
- On a rising edge with rst high, every array entry is cleared to 0 and wr_count is cleared to 0.
- On a rising edge with commit true, array[wb_sel] takes wb_data. No other entry changes.
- Read port n:
  - 0 while rst is high.
  - Otherwise 0 if ZERO_REG=1 and rd_seln==0.
  - Otherwise wb_data if wb_we=1 and wb_sel==rd_seln (bypass).
  - Otherwise array[rd_seln].
- Both read ports are independent and may select the same register, or the register being written, in the same cycle.
- dbg_data returns array[dbg_sel], or 0 for register 0 when ZERO_REG=1. It has no bypass and is not forced to 0 during rst, so it shows true stored state.
- wr_count increments by 1 on each rising edge where commit is true and stops at 32'hFFFF_FFFF.
- A write suppressed by ZERO_REG does not increment wr_count.
- wb_we=0 leaves the array and the counter unchanged regardless of wb_sel and wb_data. wb_sel and wb_data may carry X in that case without effect.

## Timing
- Reset values: all array entries 0 and wr_count 0 after the first rst edge. rd_data1 and rd_data2 read 0 while rst is high. dbg_data reads 0 for every select after the rst edge.
- Write latency: data is visible on dbg_data the cycle after the commit edge. It is visible on rd_data1 and rd_data2 in the same cycle it is presented, through the bypass.
- Back-to-back writes to the same register on consecutive cycles: the last write wins. Each write is counted.
- When rst is asserted in the same cycle as wb_we, the write is dropped and the counter is not incremented.
- Deasserting rst: the first cycle with rst low accepts a write on its edge.
- Reads have no registered stage. Outputs settle combinationally from selects, wb_* inputs and rst.

## Test plan
- Reset check:
  - Stimulus: apply rst for 2 cycles, then sweep dbg_sel 0..31.
  - Required: dbg_data=0 for every select, wr_count=0, rd_data1=rd_data2=0 during rst.
- Write then read:
  - Stimulus: wb_we=1, wb_sel=5, wb_data=32'hDEAD_BEEF for one cycle, then wb_we=0 and rd_sel1=5.
  - Required: rd_data1=32'hDEAD_BEEF, dbg_data(5)=32'hDEAD_BEEF, wr_count=1.
- Bypass:
  - Stimulus: register 7 holds 32'h1111; drive wb_we=1, wb_sel=7, wb_data=32'h2222 with rd_sel1=rd_sel2=7.
  - Required: both ports read 32'h2222 in that cycle, while dbg_data(7) still reads 32'h1111 until the edge.
- Zero register:
  - Stimulus: with ZERO_REG=1, write 32'hFFFF_FFFF to register 0 while rd_sel1=0.
  - Required: rd_data1=0 in that cycle and after, dbg_data(0)=0, wr_count unchanged.
  - Stimulus: repeat with ZERO_REG=0.
  - Required: rd_data1=32'hFFFF_FFFF through the bypass and after the edge, wr_count incremented.
- Reset collision:
  - Stimulus: register 3 holds 32'h55; assert rst together with wb_we=1, wb_sel=3, wb_data=32'hAA.
  - Required: after the edge register 3=0 and wr_count=0. The next write of 32'hAA to register 3 with rst low succeeds and wr_count=1.
- Random stream against a reference model:
  - Stimulus: 2000 cycles of random wb_we, wb_sel, wb_data, rd_sel1, rd_sel2 and dbg_sel.
  - Required: every read matches the model, including bypass.
  - Stimulus: force the counter to 32'hFFFF_FFFE, then perform three commits.
  - Required: wr_count holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: writeback register file with two bypassed read ports, a raw debug port and a saturating commit counter.
module wb_regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_sel,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] rd_sel1,
   output logic [DATA_W-1:0] rd_data1,
   input  logic [ADDR_W-1:0] rd_sel2,
   output logic [DATA_W-1:0] rd_data2,
   input  logic [ADDR_W-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic [31:0]       wr_count
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic commit;
   assign commit = wb_we & ~rst & ~(ZERO_REG & (wb_sel == '0));
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_count <= '0;
      end else if (commit) begin
         mem[wb_sel] <= wb_data;
         if (wr_count != '1) wr_count <= wr_count + 32'd1;
      end
   end
   // wb_we gates the select compare so an X select during idle cycles never leaks into the read data
   assign rd_data1 = rst ? '0 : (ZERO_REG && rd_sel1 == '0) ? '0 : (wb_we && wb_sel == rd_sel1) ? wb_data : mem[rd_sel1];
   assign rd_data2 = rst ? '0 : (ZERO_REG && rd_sel2 == '0) ? '0 : (wb_we && wb_sel == rd_sel2) ? wb_data : mem[rd_sel2];
   assign dbg_data = (ZERO_REG && dbg_sel == '0) ? '0 : mem[dbg_sel];
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: drives a ZERO_REG=1 and a ZERO_REG=0 instance with identical stimulus against a behavioural model.
module tb_wb_regfile;
   logic clk = 1'b0, rst, wb_we;
   logic [4:0] wb_sel, rd_sel1, rd_sel2, dbg_sel;
   logic [31:0] wb_data;
   logic [31:0] rd1 [2], rd2 [2], dbg [2], cnt [2];
   logic [31:0] m [2][32];
   logic [31:0] mc [2];
   logic [31:0] cprev [2];
   int total = 0, passed = 0, failed = 0;

   always #5 clk = ~clk;

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) u0 (
      .clk(clk), .rst(rst), .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
      .rd_sel1(rd_sel1), .rd_data1(rd1[0]), .rd_sel2(rd_sel2), .rd_data2(rd2[0]),
      .dbg_sel(dbg_sel), .dbg_data(dbg[0]), .wr_count(cnt[0]));
   wb_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) u1 (
      .clk(clk), .rst(rst), .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
      .rd_sel1(rd_sel1), .rd_data1(rd1[1]), .rd_sel2(rd_sel2), .rd_data2(rd2[1]),
      .dbg_sel(dbg_sel), .dbg_data(dbg[1]), .wr_count(cnt[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input int z, input logic [4:0] s);
      if (rst) return 32'h0;
      if (z == 1 && s == 5'd0) return 32'h0;
      if (wb_we && wb_sel == s) return wb_data;
      return m[z][s];
   endfunction

   function automatic logic [31:0] exp_dbg(input int z, input logic [4:0] s);
      return (z == 1 && s == 5'd0) ? 32'h0 : m[z][s];
   endfunction

   task automatic set(input logic r, input logic we, input logic [4:0] s, input logic [31:0] d,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      rst = r; wb_we = we; wb_sel = s; wb_data = d; rd_sel1 = a; rd_sel2 = b; dbg_sel = c;
      #1;
      for (int z = 0; z < 2; z++) begin
         chk($sformatf("rd1_z%0d", z), rd1[z], exp_rd(z, rd_sel1));
         chk($sformatf("rd2_z%0d", z), rd2[z], exp_rd(z, rd_sel2));
         chk($sformatf("dbg_z%0d", z), dbg[z], exp_dbg(z, dbg_sel));
         chk($sformatf("cnt_z%0d", z), cnt[z], mc[z]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int z = 0; z < 2; z++) begin
         if (rst) begin
            for (int i = 0; i < 32; i++) m[z][i] = 32'h0;
            mc[z] = 32'h0;
         end else if (wb_we && !(z == 1 && wb_sel == 5'd0)) begin
            m[z][wb_sel] = wb_data;
            if (mc[z] != 32'hFFFF_FFFF) mc[z] = mc[z] + 32'd1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; wb_we = 1'b0; wb_sel = '0; wb_data = '0; rd_sel1 = '0; rd_sel2 = '0; dbg_sel = '0;
      tick();
      set(1, 1, 5'd9, 32'h1234, 5'd9, 5'd4, 5'd9);
      for (int z = 0; z < 2; z++) chk("rst_rd1", rd1[z], 32'h0);
      tick();
      set(1, 0, 5'd0, 32'h0, 5'd3, 5'd31, 5'd0);
      tick();
      for (int i = 0; i < 32; i++) begin
         set(0, 0, 5'd0, 32'h0, 5'd1, 5'd2, 5'(i));
         for (int z = 0; z < 2; z++) chk("rst_dbg", dbg[z], 32'h0);
      end
      for (int z = 0; z < 2; z++) chk("rst_cnt", cnt[z], 32'h0);
      // write then read
      set(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd5);
      tick();
      set(0, 0, 5'd5, 32'h0, 5'd5, 5'd5, 5'd5);
      for (int z = 0; z < 2; z++) begin
         chk("wr_rd1", rd1[z], 32'hDEAD_BEEF);
         chk("wr_dbg", dbg[z], 32'hDEAD_BEEF);
         chk("wr_cnt", cnt[z], 32'd1);
      end
      // bypass
      set(0, 1, 5'd7, 32'h1111, 5'd0, 5'd0, 5'd0);
      tick();
      set(0, 1, 5'd7, 32'h2222, 5'd7, 5'd7, 5'd7);
      for (int z = 0; z < 2; z++) begin
         chk("byp_rd1", rd1[z], 32'h2222);
         chk("byp_rd2", rd2[z], 32'h2222);
         chk("byp_dbg_old", dbg[z], 32'h1111);
      end
      tick();
      set(0, 0, 5'd7, 32'h0, 5'd7, 5'd7, 5'd7);
      for (int z = 0; z < 2; z++) chk("byp_dbg_new", dbg[z], 32'h2222);
      // zero register
      cprev = mc;
      set(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
      chk("z1_rd1_byp", rd1[1], 32'h0);
      chk("z0_rd1_byp", rd1[0], 32'hFFFF_FFFF);
      tick();
      set(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
      chk("z1_rd1", rd1[1], 32'h0);
      chk("z1_dbg", dbg[1], 32'h0);
      chk("z1_cnt", cnt[1], cprev[1]);
      chk("z0_rd1", rd1[0], 32'hFFFF_FFFF);
      chk("z0_dbg", dbg[0], 32'hFFFF_FFFF);
      chk("z0_cnt", cnt[0], cprev[0] + 32'd1);
      // reset collision
      set(0, 1, 5'd3, 32'h55, 5'd3, 5'd0, 5'd3);
      tick();
      set(1, 1, 5'd3, 32'hAA, 5'd3, 5'd3, 5'd3);
      for (int z = 0; z < 2; z++) chk("col_rd1", rd1[z], 32'h0);
      tick();
      set(0, 0, 5'd3, 32'h0, 5'd3, 5'd3, 5'd3);
      for (int z = 0; z < 2; z++) begin
         chk("col_dbg", dbg[z], 32'h0);
         chk("col_cnt", cnt[z], 32'h0);
      end
      set(0, 1, 5'd3, 32'hAA, 5'd3, 5'd3, 5'd3);
      tick();
      set(0, 0, 5'd3, 32'h0, 5'd3, 5'd3, 5'd3);
      for (int z = 0; z < 2; z++) begin
         chk("col2_dbg", dbg[z], 32'hAA);
         chk("col2_cnt", cnt[z], 32'd1);
      end
      // random stream
      for (int n = 0; n < 2000; n++) begin
         set(0, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
         tick();
      end
      // saturation
      force u0.wr_count = 32'hFFFF_FFFE;
      force u1.wr_count = 32'hFFFF_FFFE;
      #1;
      release u0.wr_count;
      release u1.wr_count;
      mc[0] = 32'hFFFF_FFFE;
      mc[1] = 32'hFFFF_FFFE;
      for (int n = 0; n < 3; n++) begin
         set(0, 1, 5'(n + 1), $urandom, 5'(n + 1), 5'd0, 5'(n + 1));
         tick();
      end
      set(0, 0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3);
      for (int z = 0; z < 2; z++) chk("sat_cnt", cnt[z], 32'hFFFF_FFFF);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
